// File: rtl/wb_arbiter_rr2.sv
// rtl/wb_arbiter_rr2.sv - two-requester round-robin Wishbone arbiter with outstanding-transfer tracking
module wb_arbiter_rr2 #(
  parameter int ADDR_WIDTH = 8
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [1:0]              s_cyc_i,
  input  logic [1:0]              s_stb_i,
  input  logic [1:0]              s_we_i,
  input  logic [7:0]              s_sel_i,
  input  logic [2*ADDR_WIDTH-1:0] s_adr_i,
  input  logic [63:0]             s_dat_i,
  output logic [1:0]              s_ack_o,
  output logic [1:0]              s_err_o,
  output logic [1:0]              s_rty_o,
  output logic [1:0]              s_stall_o,
  output logic [31:0]             s_dat_o,
  output logic                    m_cyc_o,
  output logic                    m_stb_o,
  output logic                    m_we_o,
  output logic [3:0]              m_sel_o,
  output logic [ADDR_WIDTH-1:0]   m_adr_o,
  output logic [31:0]             m_dat_o,
  input  logic                    m_ack_i,
  input  logic                    m_err_i,
  input  logic                    m_rty_i,
  input  logic                    m_stall_i,
  input  logic [31:0]             m_dat_i,
  output logic [1:0]              gnt_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN0 = 2'd1,
    ST_OWN1 = 2'd2
  } state_e;

  state_e     state_q, state_d;
  logic       last_q, last_d;
  logic [1:0] outst_q, outst_d;

  logic       owning;
  logic       owner;
  logic       outst_full;
  logic       accept;
  logic       term;

  // Owner index is only meaningful while owning; IDLE masks everything it selects.
  assign owning     = (state_q != ST_IDLE);
  assign owner      = (state_q == ST_OWN1);
  assign outst_full = (outst_q == 2'd3);
  assign accept     = m_stb_o & ~m_stall_i;
  assign term       = m_ack_i | m_err_i | m_rty_i;

  assign gnt_o   = {state_q == ST_OWN1, state_q == ST_OWN0};
  assign s_dat_o = m_dat_i;

  // Request path: forward the owner's signals to the slave, all zero when idle.
  always_comb begin
    m_cyc_o = 1'b0;
    m_stb_o = 1'b0;
    m_we_o  = 1'b0;
    m_sel_o = 4'h0;
    m_adr_o = '0;
    m_dat_o = 32'h0;
    if (owning) begin
      m_cyc_o = s_cyc_i[owner];
      // Hold off new requests once three are in flight so the counter never overflows.
      m_stb_o = s_stb_i[owner] & ~outst_full;
      m_we_o  = s_we_i[owner];
      m_sel_o = owner ? s_sel_i[7:4] : s_sel_i[3:0];
      m_adr_o = owner ? s_adr_i[2*ADDR_WIDTH-1:ADDR_WIDTH] : s_adr_i[ADDR_WIDTH-1:0];
      m_dat_o = owner ? s_dat_i[63:32] : s_dat_i[31:0];
    end
  end

  // Return path: terminations reach only the owner; the non-owner always sees stall.
  always_comb begin
    s_ack_o   = 2'b00;
    s_err_o   = 2'b00;
    s_rty_o   = 2'b00;
    s_stall_o = 2'b11;
    if (owning) begin
      s_ack_o[owner]   = m_ack_i;
      s_err_o[owner]   = m_err_i;
      s_rty_o[owner]   = m_rty_i;
      s_stall_o[owner] = m_stall_i | outst_full;
    end
  end

  // Next-state: round-robin grant from IDLE, release on cyc drop, saturating in-flight count.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    outst_d = outst_q;
    case (state_q)
      ST_IDLE: begin
        // Late terminations arriving while idle are dropped and never counted.
        outst_d = 2'd0;
        if (s_cyc_i == 2'b11) begin
          state_d = last_q ? ST_OWN0 : ST_OWN1;
          last_d  = ~last_q;
        end else if (s_cyc_i[0]) begin
          state_d = ST_OWN0;
          last_d  = 1'b0;
        end else if (s_cyc_i[1]) begin
          state_d = ST_OWN1;
          last_d  = 1'b1;
        end
      end
      ST_OWN0, ST_OWN1: begin
        if (!s_cyc_i[owner]) begin
          // Dropping cyc aborts the bus cycle; anything still in flight is abandoned.
          state_d = ST_IDLE;
          outst_d = 2'd0;
        end else if (accept && !term) begin
          if (outst_q != 2'd3) begin
            outst_d = outst_q + 2'd1;
          end
        end else if (term && !accept) begin
          if (outst_q != 2'd0) begin
            outst_d = outst_q - 2'd1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        outst_d = 2'd0;
      end
    endcase
  end

  // State registers; last resets to 1 so requester 0 wins the first contention.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      last_q  <= 1'b1;
      outst_q <= 2'd0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      outst_q <= outst_d;
    end
  end

endmodule

// File: tb/tb_wb_arbiter_rr2.sv
// tb/tb_wb_arbiter_rr2.sv - scoreboard bench for wb_arbiter_rr2
module tb_wb_arbiter_rr2;

  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          rst_i;
  logic [1:0]    s_cyc_i, s_stb_i, s_we_i;
  logic [7:0]    s_sel_i;
  logic [2*AW-1:0] s_adr_i;
  logic [63:0]   s_dat_i;
  logic [1:0]    s_ack_o, s_err_o, s_rty_o, s_stall_o;
  logic [31:0]   s_dat_o;
  logic          m_cyc_o, m_stb_o, m_we_o;
  logic [3:0]    m_sel_o;
  logic [AW-1:0] m_adr_o;
  logic [31:0]   m_dat_o;
  logic          m_ack_i, m_err_i, m_rty_i, m_stall_i;
  logic [31:0]   m_dat_i;
  logic [1:0]    gnt_o;

  typedef struct {
    logic [1:0]  ack;
    logic [1:0]  err;
    logic [1:0]  rty;
    logic [31:0] dat;
  } resp_t;

  resp_t exp_q[$];
  int total = 0;
  int bad   = 0;
  logic [31:0] pipe_vals [4];

  always #5 clk = ~clk;

  wb_arbiter_rr2 #(.ADDR_WIDTH(AW)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .s_cyc_i(s_cyc_i), .s_stb_i(s_stb_i), .s_we_i(s_we_i), .s_sel_i(s_sel_i),
    .s_adr_i(s_adr_i), .s_dat_i(s_dat_i),
    .s_ack_o(s_ack_o), .s_err_o(s_err_o), .s_rty_o(s_rty_o), .s_stall_o(s_stall_o),
    .s_dat_o(s_dat_o),
    .m_cyc_o(m_cyc_o), .m_stb_o(m_stb_o), .m_we_o(m_we_o), .m_sel_o(m_sel_o),
    .m_adr_o(m_adr_o), .m_dat_o(m_dat_o),
    .m_ack_i(m_ack_i), .m_err_i(m_err_i), .m_rty_i(m_rty_i), .m_stall_i(m_stall_i),
    .m_dat_i(m_dat_i),
    .gnt_o(gnt_o)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic [1:0] a, input logic [1:0] e, input logic [1:0] r,
                      input logic [31:0] d);
    resp_t x;
    x.ack = a;
    x.err = e;
    x.rty = r;
    x.dat = d;
    exp_q.push_back(x);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    #1;
  endtask

  // Any termination presented to a requester must match the next scoreboard entry.
  always @(negedge clk) begin
    if ((s_ack_o | s_err_o | s_rty_o) != 2'b00) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_resp: ack=%b err=%b rty=%b expected none at %0t",
                 s_ack_o, s_err_o, s_rty_o, $time);
      end else begin
        resp_t x;
        x = exp_q.pop_front();
        chk("resp_ack", 32'(s_ack_o), 32'(x.ack));
        chk("resp_err", 32'(s_err_o), 32'(x.err));
        chk("resp_rty", 32'(s_rty_o), 32'(x.rty));
        chk("resp_dat", s_dat_o, x.dat);
      end
    end
  end

  // Entered settled in an OWNn cycle with requester n strobing a single read.
  task automatic own_read(input int n, input logic [7:0] adr, input logic [31:0] dat);
    chk("own_gnt", 32'(gnt_o), 32'(1 << n));
    chk("own_adr", 32'(m_adr_o), 32'(adr));
    chk("own_stb", 32'(m_stb_o), 32'd1);
    tick;
    s_stb_i[n] = 1'b0;
    m_ack_i    = 1'b1;
    m_dat_i    = dat;
    push(2'(1 << n), 2'b00, 2'b00, dat);
    settle;
    tick;
    m_ack_i    = 1'b0;
    m_dat_i    = 32'h0;
    s_cyc_i[n] = 1'b0;
    settle;
    chk("own_gnt_release", 32'(gnt_o), 32'(1 << n));
    tick;
    settle;
    chk("own_gnt_idle", 32'(gnt_o), 32'd0);
  endtask

  task automatic do_reset;
    tick;
    rst_i   = 1'b1;
    s_cyc_i = 2'b00;
    s_stb_i = 2'b00;
    s_we_i  = 2'b00;
    tick;
    rst_i = 1'b0;
    settle;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, expected finish");
    $fatal(1);
  end

  initial begin
    pipe_vals[0] = 32'h11;
    pipe_vals[1] = 32'h22;
    pipe_vals[2] = 32'h33;
    pipe_vals[3] = 32'h44;
    rst_i = 1'b1;
    s_cyc_i = 2'b00; s_stb_i = 2'b00; s_we_i = 2'b00; s_sel_i = 8'h00;
    s_adr_i = '0; s_dat_i = 64'h0;
    m_ack_i = 1'b0; m_err_i = 1'b0; m_rty_i = 1'b0; m_stall_i = 1'b0; m_dat_i = 32'h0;

    // Reset state
    tick;
    tick;
    settle;
    chk("rst_gnt", 32'(gnt_o), 32'd0);
    chk("rst_m_cyc_stb_we", 32'({m_cyc_o, m_stb_o, m_we_o}), 32'd0);
    chk("rst_m_sel", 32'(m_sel_o), 32'd0);
    chk("rst_m_adr", 32'(m_adr_o), 32'd0);
    chk("rst_m_dat", m_dat_o, 32'd0);
    chk("rst_s_term", 32'({s_ack_o, s_err_o, s_rty_o}), 32'd0);
    chk("rst_s_stall", 32'(s_stall_o), 32'h3);

    // Single master write, slave acks two cycles after acceptance
    tick;
    rst_i = 1'b0;
    s_cyc_i = 2'b01; s_stb_i = 2'b01; s_we_i = 2'b01;
    s_sel_i[3:0] = 4'hF; s_adr_i[AW-1:0] = 8'h00; s_dat_i[31:0] = 32'h2;
    settle;
    chk("wr_gnt_req_cycle", 32'(gnt_o), 32'd0);
    tick;
    settle;
    chk("wr_gnt", 32'(gnt_o), 32'h1);
    chk("wr_m_cyc_stb_we", 32'({m_cyc_o, m_stb_o, m_we_o}), 32'h7);
    chk("wr_m_adr", 32'(m_adr_o), 32'h00);
    chk("wr_m_dat", m_dat_o, 32'h2);
    chk("wr_m_sel", 32'(m_sel_o), 32'hF);
    chk("wr_stall", 32'(s_stall_o), 32'h2);
    tick;
    s_stb_i = 2'b00;
    settle;
    chk("wr_no_early_ack", 32'(s_ack_o), 32'd0);
    tick;
    m_ack_i = 1'b1;
    push(2'b01, 2'b00, 2'b00, 32'h0);
    settle;
    tick;
    m_ack_i = 1'b0;
    settle;
    chk("wr_ack_one_cycle", 32'(s_ack_o), 32'd0);
    tick;
    s_cyc_i = 2'b00; s_we_i = 2'b00;
    settle;
    tick;
    settle;
    chk("wr_idle", 32'(gnt_o), 32'd0);

    // Contention straight after reset: 01, 00, 10
    do_reset;
    tick;
    s_cyc_i = 2'b11; s_stb_i = 2'b11;
    s_adr_i = {8'h20, 8'h10};
    settle;
    chk("cont1_idle", 32'(gnt_o), 32'd0);
    tick;
    settle;
    own_read(0, 8'h10, 32'hA1);
    tick;
    settle;
    own_read(1, 8'h20, 32'hB2);

    // Requester 1 pipelined reads, 1-cycle ack, no stall
    tick;
    s_cyc_i = 2'b10; s_stb_i = 2'b10; s_adr_i[2*AW-1:AW] = 8'h30;
    settle;
    for (int k = 0; k < 5; k++) begin
      tick;
      m_ack_i = (k > 0);
      m_dat_i = (k > 0) ? pipe_vals[k-1] : 32'h0;
      if (k > 0) push(2'b10, 2'b00, 2'b00, pipe_vals[k-1]);
      if (k == 4) s_stb_i = 2'b00;
      settle;
      if (k == 0) chk("pipe_gnt", 32'(gnt_o), 32'h2);
      if (k < 4) chk("pipe_stall", 32'(s_stall_o[1]), 32'd0);
    end
    tick;
    m_ack_i = 1'b0; m_dat_i = 32'h0; s_cyc_i = 2'b00;
    settle;
    tick;
    settle;
    chk("pipe_idle", 32'(gnt_o), 32'd0);

    // Abort with one outstanding; late ack is discarded
    tick;
    s_cyc_i = 2'b01; s_stb_i = 2'b01; s_adr_i[AW-1:0] = 8'h40;
    settle;
    tick;
    settle;
    chk("abort_gnt", 32'(gnt_o), 32'h1);
    tick;
    s_stb_i = 2'b00; s_cyc_i = 2'b00;
    settle;
    chk("abort_gnt_release", 32'(gnt_o), 32'h1);
    tick;
    m_ack_i = 1'b1;
    settle;
    chk("abort_idle", 32'(gnt_o), 32'd0);
    chk("abort_ack_dropped", 32'(s_ack_o), 32'd0);
    tick;
    m_ack_i = 1'b0;
    s_cyc_i = 2'b01; s_stb_i = 2'b01;
    settle;
    // A cleared counter lets exactly three requests through before stall
    for (int k = 0; k < 4; k++) begin
      tick;
      settle;
      chk("abort_refill_stall", 32'(s_stall_o[0]), 32'(k == 3));
      chk("abort_refill_stb", 32'(m_stb_o), 32'(k < 3));
    end
    tick;
    s_cyc_i = 2'b00; s_stb_i = 2'b00;
    settle;
    tick;
    settle;
    chk("abort2_idle", 32'(gnt_o), 32'd0);

    // Repeat contention with requester 0 last granted: 10, 00, 01
    tick;
    s_cyc_i = 2'b11; s_stb_i = 2'b11;
    s_adr_i = {8'h60, 8'h50};
    settle;
    chk("cont2_idle", 32'(gnt_o), 32'd0);
    tick;
    settle;
    own_read(1, 8'h60, 32'hC3);
    tick;
    settle;
    own_read(0, 8'h50, 32'hD4);

    // Error and retry on requester 1, starting from a full pipeline
    tick;
    s_cyc_i = 2'b10; s_stb_i = 2'b10; s_adr_i[2*AW-1:AW] = 8'h70;
    settle;
    for (int k = 0; k < 3; k++) begin
      tick;
      settle;
      chk("er_fill_stall", 32'(s_stall_o[1]), 32'd0);
    end
    tick;
    m_err_i = 1'b1;
    push(2'b00, 2'b10, 2'b00, 32'h0);
    settle;
    chk("er_full_stall", 32'(s_stall_o[1]), 32'd1);
    chk("er_full_stb", 32'(m_stb_o), 32'd0);
    tick;
    m_err_i = 1'b0; m_rty_i = 1'b1; s_stb_i = 2'b00;
    push(2'b00, 2'b00, 2'b10, 32'h0);
    settle;
    chk("er_after_err_stall", 32'(s_stall_o[1]), 32'd0);
    tick;
    m_rty_i = 1'b0; m_ack_i = 1'b1;
    push(2'b10, 2'b00, 2'b00, 32'h0);
    settle;
    tick;
    m_ack_i = 1'b0; s_stb_i = 2'b10;
    settle;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) begin
        tick;
        settle;
      end
      chk("er_refill_stall", 32'(s_stall_o[1]), 32'(k == 3));
    end
    tick;
    s_stb_i = 2'b00; m_ack_i = 1'b1;
    push(2'b10, 2'b00, 2'b00, 32'h0);
    settle;

    // Synchronous reset while OWN1 with two outstanding
    tick;
    m_ack_i = 1'b0; rst_i = 1'b1; s_cyc_i = 2'b11;
    settle;
    chk("rst2_pre_gnt", 32'(gnt_o), 32'h2);
    tick;
    rst_i = 1'b0;
    settle;
    chk("rst2_gnt", 32'(gnt_o), 32'd0);
    chk("rst2_m_cyc", 32'(m_cyc_o), 32'd0);
    chk("rst2_stall", 32'(s_stall_o), 32'h3);
    tick;
    settle;
    chk("rst2_first_gnt", 32'(gnt_o), 32'h1);
    tick;
    s_cyc_i = 2'b00;
    settle;
    tick;
    settle;
    chk("rst2_final_idle", 32'(gnt_o), 32'd0);

    tick;
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wb_arbiter_rr2.md
# wb_arbiter_rr2

Two-requester round-robin arbiter that shares one pipelined Wishbone slave between two Wishbone masters, typically a generated register block such as a strobe/control bank. Each master gets exclusive ownership of the slave for the whole of its bus cycle, with `cyc` held high. Ownership alternates fairly when both masters contend. The block tracks outstanding transfers so that acks, errors and read data always return to the owner that issued them.

## Interface
- `ADDR_WIDTH`, default 8: width of each address bus.
- `clk_i`  in  1: single clock; every register is clocked on its rising edge.
- `rst_i`  in  1: synchronous, active-high reset.
- `s_cyc_i`  in  2: per-requester `cyc`; bit n belongs to requester n.
- `s_stb_i`  in  2: per-requester `stb`.
- `s_we_i`  in  2: per-requester write enable.
- `s_sel_i`  in  8: byte selects; bits [4n+3:4n] belong to requester n.
- `s_adr_i`  in  2*ADDR_WIDTH: addresses, packed the same way as `s_sel_i`.
- `s_dat_i`  in  64: write data; bits [32n+31:32n] belong to requester n.
- `s_ack_o`, `s_err_o`, `s_rty_o`  out  2 each: per-requester terminations.
- `s_stall_o`  out  2: per-requester stall.
- `s_dat_o`  out  32: shared read data; valid only alongside the owner's `s_ack_o` bit.
- `m_cyc_o`, `m_stb_o`, `m_we_o`  out  1 each: slave-side master signals.
- `m_sel_o`  out  4: slave-side byte selects.
- `m_adr_o`  out  ADDR_WIDTH: slave-side address.
- `m_dat_o`  out  32: slave-side write data.
- `m_ack_i`, `m_err_i`, `m_rty_i`, `m_stall_i`  in  1 each: slave responses.
- `m_dat_i`  in  32: slave read data.
- `gnt_o`  out  2: one-hot current owner; 00 when idle.

## Operation
- FSM states are IDLE, OWN0 and OWN1. `gnt_o` is decoded from the state.
- Registers:
  - `last` (1 bit): most recently granted requester; reset value 1, so requester 0 wins first contention.
  - `outst` (2 bits): count of accepted, uncompleted requests.
- IDLE transitions:
  - Only `s_cyc_i[n]` is high: go to OWNn.
  - Both are high: go to OWN(~`last`).
  - Neither is high: stay in IDLE.
  - On every grant, `last` is set to the winner.
- OWNn:
  - `m_cyc_o` = `s_cyc_i[n]`.
  - `m_stb_o` = `s_stb_i[n]` & (`outst` != 3).
  - `m_we_o`, `m_sel_o`, `m_adr_o` and `m_dat_o` are muxed from requester n.
- In IDLE, every `m_*` output is 0.
- Return path:
  - `s_ack_o[n]`, `s_err_o[n]` and `s_rty_o[n]` equal the corresponding `m_*_i` only while in OWNn; otherwise 0.
  - `s_stall_o[n]` = `m_stall_i` | (`outst` == 3) while in OWNn; otherwise 1.
  - `s_dat_o` = `m_dat_i`, passed through unconditionally.
- `outst` counting:
  - +1 on acceptance (`m_stb_o` & ~`m_stall_i`).
  - −1 on any termination (`m_ack_i` | `m_err_i` | `m_rty_i`).
  - Acceptance and termination in the same cycle leave `outst` unchanged.
  - Saturates: it never wraps past 3 or below 0.
- Release: while in OWNn, `s_cyc_i[n]` low means next state IDLE and `outst` cleared to 0. Dropping `cyc` aborts the cycle per Wishbone rules, so outstanding responses are abandoned.
- Terminations from the slave while in IDLE are discarded and not routed to either requester.
- Reset mid-cycle: state returns to IDLE, `outst` to 0 and `last` to 1; all `m_*` outputs drop the following cycle.

## Timing
- Reset values:
  - `gnt_o` = 00; `m_cyc_o`, `m_stb_o`, `m_we_o` = 0; `m_sel_o`, `m_adr_o`, `m_dat_o` = 0.
  - `s_ack_o`, `s_err_o`, `s_rty_o` = 00; `s_stall_o` = 11.
- Grant latency: `s_cyc_i` seen high in cycle N (IDLE) gives OWN in N+1, and `m_cyc_o`/`m_stb_o` are asserted combinationally in N+1.
- Release latency: `s_cyc_i[n]` low in cycle N gives IDLE in N+1. The earliest new grant is in N+2, so there is at least one idle cycle between owners.
- All datapath and return muxing is combinational off the state register. The arbiter adds no latency to slave responses.

## Test plan
- Single master write:
  - Stimulus: requester 0 writes 0x00000002 to address 0x00 with `sel` = 0xF, against a slave model that acks 2 cycles after acceptance.
  - Required: `gnt_o` = 01 one cycle after `cyc`; slave sees the exact address, data and `sel`; `s_ack_o` = 01 for exactly one cycle; `s_ack_o[1]` stays 0 throughout.
- Contention round-robin:
  - Stimulus: both masters raise `cyc` in the same cycle after reset, each doing one read and then dropping `cyc`.
  - Required: grant order is 01, 00, 10. On a repeat contention the order is 10, 00, 01.
- Pipelined reads:
  - Stimulus: requester 1 issues 4 back-to-back reads; slave has 1-cycle ack and never stalls.
  - Required:
    - `s_stall_o[1]` is forced high for one cycle only if `outst` reaches 3.
    - Exactly 4 acks are returned.
    - `s_dat_o` carries the slave data 0x11, 0x22, 0x33, 0x44 in order.
- Abort:
  - Stimulus: requester 0 drops `cyc` with `outst` = 1; the slave acks a cycle later.
  - Required: state is IDLE; the ack is not routed to either requester; `outst` = 0.
- Error and retry:
  - Stimulus: slave answers `m_err_i`, then `m_rty_i`.
  - Required: each is routed only to the owner and decrements `outst` like an ack.
- Synchronous reset:
  - Stimulus: `rst_i` is pulsed while in OWN1 with `outst` = 2.
  - Required: next cycle shows IDLE, `m_cyc_o` = 0, `s_stall_o` = 11, and a subsequent contention grants requester 0 first.
